ex_wb_stage: RTL and testbench

- Writeback stage directly downstream of the EX (ALU) stage.
- Captures each valid {opcode_ex, alu_out} pair into a small in-order result buffer and presents the results to a consumer over a valid/ready interface.
- Raises stall to freeze the IF, IF/ID and ID/EX stages while the buffer is full.
- Keeps a retired-result counter for debug and performance checks.

---
 rtl/ex_wb_stage.sv | 77 +++++++
 tb/tb_ex_wb_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_stage.sv
// Writeback stage: in-order result buffer between EX and the consumer, with
// full-buffer stall back to IF, IF/ID and ID/EX, plus a retired-result counter.
module ex_wb_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     ex_valid,
    input  logic [3:0]               opcode_ex,
    input  logic [7:0]               alu_out,
    output logic                     stall,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [3:0]               wb_opcode,
    output logic [7:0]               wb_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         retired
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // Handshakes: push = ex_valid && !stall; pop = wb_valid && wb_ready.
    // A transfer happens on the rising edge where its condition is high.
    logic [11:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic [CNT_W-1:0] r_retired;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_nonempty;

    assign w_full     = (r_count == FULL);
    assign w_nonempty = (r_count != '0);
    assign w_push     = ex_valid && !w_full;
    assign w_pop      = w_nonempty && wb_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {opcode_ex, alu_out};
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_retired <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_retired <= r_retired + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Head is masked while empty so stale memory never leaks onto wb_*.
    assign stall     = w_full;
    assign wb_valid  = w_nonempty;
    assign wb_opcode = w_nonempty ? r_mem[r_rd_ptr][11:8] : 4'h0;
    assign wb_data   = w_nonempty ? r_mem[r_rd_ptr][7:0]  : 8'h00;
    assign count     = r_count;
    assign retired   = r_retired;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: per-cycle scoreboard model plus targeted
// checks for stall timing, backpressure hold, async reset and counter wrap.
module tb_ex_wb_stage;
  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid;
  logic [3:0]  opcode_ex;
  logic [7:0]  alu_out;
  logic        wb_ready;
  logic        stall, stall4;
  logic        wb_valid, wb_valid4;
  logic [3:0]  wb_opcode, wb_opcode4;
  logic [7:0]  wb_data, wb_data4;
  logic [2:0]  count, count4;
  logic [15:0] retired;
  logic [3:0]  retired4;

  logic [11:0] exp_q[$];
  int          m_cnt;
  int          m_ret;
  int          pass_cnt;
  int          fail_cnt;
  int          total_cnt;
  int          ret_base;

  ex_wb_stage #(.DEPTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .opcode_ex(opcode_ex),
    .alu_out(alu_out), .stall(stall), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_opcode(wb_opcode), .wb_data(wb_data), .count(count), .retired(retired)
  );

  ex_wb_stage #(.DEPTH(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .opcode_ex(opcode_ex),
    .alu_out(alu_out), .stall(stall4), .wb_valid(wb_valid4), .wb_ready(wb_ready),
    .wb_opcode(wb_opcode4), .wb_data(wb_data4), .count(count4), .retired(retired4)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    m_cnt = 0;
    m_ret = 0;
  endtask

  // One clock: at the falling edge compare against the model and account for
  // the transfers the coming rising edge will perform, then step past it.
  task automatic cycle();
    logic       do_push;
    logic       do_pop;
    logic [11:0] head;
    @(negedge clk);
    if (!rstn) begin
      model_flush();
    end else begin
      chk("stall", {31'd0, stall}, {31'd0, (m_cnt == 4)});
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, (m_cnt != 0)});
      chk("count", {29'd0, count}, m_cnt);
      chk("retired", {16'd0, retired}, m_ret & 32'hFFFF);
      chk("retired4", {28'd0, retired4}, m_ret & 32'hF);
      do_pop  = (m_cnt != 0) && wb_ready;
      do_push = ex_valid && (m_cnt != 4);
      if (do_pop) begin
        head = exp_q.pop_front();
        chk("pop_head", {20'd0, wb_opcode, wb_data}, {20'd0, head});
        m_ret++;
      end
      if (do_push) exp_q.push_back({opcode_ex, alu_out});
      m_cnt = m_cnt + int'(do_push) - int'(do_pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] d, input logic rdy);
    ex_valid  = v;
    opcode_ex = op;
    alu_out   = d;
    wb_ready  = rdy;
  endtask

  initial begin
    pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
    model_flush();
    drive(1'b0, 4'h0, 8'h00, 1'b0);

    // Reset then idle
    rstn = 1'b0;
    repeat (3) cycle();
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_retired", {16'd0, retired}, 0);
    chk("rst_wb_data", {24'd0, wb_data}, 0);
    chk("rst_wb_opcode", {28'd0, wb_opcode}, 0);
    rstn = 1'b1;
    cycle();

    // Single pass-through
    drive(1'b1, 4'h1, 8'h2A, 1'b1);
    cycle();
    drive(1'b0, 4'h0, 8'h00, 1'b1);
    chk("pt_valid", {31'd0, wb_valid}, 1);
    chk("pt_opcode", {28'd0, wb_opcode}, 4'h1);
    chk("pt_data", {24'd0, wb_data}, 8'h2A);
    cycle();
    chk("pt_retired", {16'd0, retired}, 1);
    chk("pt_count", {29'd0, count}, 0);

    // Fill to full, then hold 8'h14 while stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h2, 8'h10 + 8'(i), 1'b0);
      cycle();
    end
    drive(1'b1, 4'h2, 8'h14, 1'b0);
    repeat (2) cycle();
    chk("full_count", {29'd0, count}, 4);
    chk("full_stall", {31'd0, stall}, 1);
    chk("full_head", {24'd0, wb_data}, 8'h10);
    wb_ready = 1'b1;
    cycle();
    wb_ready = 1'b0;
    chk("unstall_stall", {31'd0, stall}, 0);
    chk("unstall_count", {29'd0, count}, 3);
    cycle();
    drive(1'b0, 4'h0, 8'h00, 1'b0);
    chk("refill_count", {29'd0, count}, 4);
    repeat (2) cycle();
    wb_ready = 1'b1;
    repeat (5) cycle();
    wb_ready = 1'b0;
    chk("drain_count", {29'd0, count}, 0);
    chk("drain_q_empty", exp_q.size(), 0);

    // Simultaneous push and pop at count=1
    drive(1'b1, 4'h3, 8'hA0, 1'b0);
    cycle();
    ret_base = m_ret;
    drive(1'b1, 4'h3, 8'hA1, 1'b1);
    cycle();
    drive(1'b0, 4'h0, 8'h00, 1'b0);
    chk("pp_count", {29'd0, count}, 1);
    chk("pp_valid", {31'd0, wb_valid}, 1);
    chk("pp_data", {24'd0, wb_data}, 8'hA1);
    chk("pp_retired", {16'd0, retired}, ret_base + 1);
    wb_ready = 1'b1;
    cycle();

    // Backpressure hold
    drive(1'b1, 4'h5, 8'h55, 1'b0);
    cycle();
    drive(1'b0, 4'h0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, wb_valid}, 1);
      chk("bp_data", {24'd0, wb_data}, 8'h55);
      chk("bp_opcode", {28'd0, wb_opcode}, 4'h5);
      cycle();
    end

    // Reach count=3, then async reset pulse between edges
    drive(1'b1, 4'h6, 8'h60, 1'b0);
    cycle();
    alu_out = 8'h61;
    cycle();
    drive(1'b0, 4'h0, 8'h00, 1'b0);
    chk("pre_rst_count", {29'd0, count}, 3);
    #1;
    rstn = 1'b0;
    #1;
    chk("async_count", {29'd0, count}, 0);
    chk("async_valid", {31'd0, wb_valid}, 0);
    chk("async_retired", {16'd0, retired}, 0);
    rstn = 1'b1;
    model_flush();
    drive(1'b1, 4'h7, 8'h77, 1'b0);
    cycle();
    drive(1'b0, 4'h0, 8'h00, 1'b0);
    chk("post_rst_wr_ptr", {30'd0, u_dut.r_wr_ptr}, 1);
    chk("post_rst_head", {20'd0, wb_opcode, wb_data}, 12'h777);
    wb_ready = 1'b1;
    cycle();

    // Back-to-back throughput and retired wrap on the 4-bit counter
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      drive(i < 17, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b1);
      cycle();
      if (i > 0 && i < 17) chk("tput_count", {29'd0, count}, 1);
    end
    drive(1'b0, 4'h0, 8'h00, 1'b0);
    chk("wrap_retired4", {28'd0, retired4}, 1);
    chk("wrap_retired16", {16'd0, retired}, 17);
    cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
